imm_decode: RTL and testbench

Decode stage directly upstream of `load_store_instructions`. Accepts RV32I instruction words from fetch over a valid/ready handshake and extracts the register destination and immediate. Drives `control_li`, the 32-bit `immediate` and `rd` into the load/store stage from a registered output. Fuses an `LUI rd` followed by `ADDI rd, rd, imm` into a single load-immediate carrying the full 32-bit constant.

---
 rtl/mk1_isa_pkg.sv | 40 ++++
 rtl/imm_extract.sv | 50 +++++
 rtl/imm_decode.sv | 182 ++++++++++++++++++
 tb/tb_imm_decode.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mk1_isa_pkg.sv
// Shared RV32I decode definitions: opcode constants, decoded-op encoding,
// FSM/mux enums and immediate extraction helpers.
package mk1_isa_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    OP_LI    = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_PASS  = 2'd3
  } dec_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_DEC  = 2'd0,
    SEL_HOLD = 2'd1,
    SEL_FUSE = 2'd2
  } out_sel_t;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32I field/immediate decoder feeding the imm_decode FSM.
module imm_extract
  import mk1_isa_pkg::*;
(
  input  logic [31:0] instr,
  output dec_op_t     op,
  output logic [31:0] imm,
  output logic [31:0] imm12,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic        is_lui_nz,
  output logic        is_addi
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] field_rd;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign field_rd = instr[11:7];
  assign rs1      = instr[19:15];
  assign imm12    = imm_i(instr);

  assign is_lui_nz = (opcode == OPC_LUI) && (field_rd != 5'd0);
  assign is_addi   = (opcode == OPC_OPIMM) && (funct3 == 3'b000);

  always_comb begin
    op  = OP_PASS;
    imm = imm_i(instr);
    rd  = field_rd;
    case (opcode)
      OPC_LUI: begin
        op  = OP_LI;
        imm = imm_u(instr);
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b000 && rs1 == 5'd0) op = OP_LI;
      end
      OPC_LOAD:  op = OP_LOAD;
      OPC_STORE: begin
        op  = OP_STORE;
        imm = imm_s(instr);
        rd  = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_decode.sv
// Decode stage ahead of load/store: extracts rd/immediate and fuses
// LUI rd + ADDI rd,rd,imm into one load-immediate.
module imm_decode
  import mk1_isa_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        flush,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic        control_li,
  output logic [1:0]  dec_op,
  output logic [31:0] immediate,
  output logic [4:0]  rd,
  output logic [31:0] dec_instr
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  dec_op_t     x_op;
  logic [31:0] x_imm, x_imm12;
  logic [4:0]  x_rd, x_rs1;
  logic        x_lui_nz, x_addi;

  imm_extract u_extract (
    .instr     (instr),
    .op        (x_op),
    .imm       (x_imm),
    .imm12     (x_imm12),
    .rd        (x_rd),
    .rs1       (x_rs1),
    .is_lui_nz (x_lui_nz),
    .is_addi   (x_addi)
  );

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] hold_instr_q;
  logic        dec_valid_q;
  dec_op_t     dec_op_q;
  logic [31:0] imm_q, instr_q;
  logic [4:0]  rd_q;

  logic        free, fusable, load_out, capture, cnt_inc;
  out_sel_t    sel;
  logic [4:0]  hold_rd;
  logic [31:0] hold_imm;
  dec_op_t     op_d;
  logic [31:0] imm_d, word_d;
  logic [4:0]  rd_d;

  assign free     = !dec_valid_q || dec_ready;
  assign hold_rd  = hold_instr_q[11:7];
  assign hold_imm = imm_u(hold_instr_q);
  assign fusable  = x_addi && (x_rd == hold_rd) && (x_rs1 == hold_rd);

  // Next-state and handshake control.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    load_out    = 1'b0;
    capture     = 1'b0;
    cnt_inc     = 1'b0;
    sel         = SEL_DEC;
    if (!rst && !flush) begin
      case (state_q)
        ST_IDLE: begin
          instr_ready = free;
          if (instr_valid && free) begin
            if (x_lui_nz) begin
              capture = 1'b1;
              state_d = ST_HELD;
            end else begin
              load_out = 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (instr_valid) begin
            if (fusable) begin
              instr_ready = free;
              if (free) begin
                load_out = 1'b1;
                sel      = SEL_FUSE;
                state_d  = ST_IDLE;
              end
            end else if (x_lui_nz) begin
              instr_ready = free;
              if (free) begin
                load_out = 1'b1;
                sel      = SEL_HOLD;
                capture  = 1'b1;
              end
            end else if (free) begin
              // Flush the held LUI first; the stalled word enters from IDLE.
              load_out = 1'b1;
              sel      = SEL_HOLD;
              state_d  = ST_IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
            if (cnt_q == HOLD_LIM && free) begin
              load_out = 1'b1;
              sel      = SEL_HOLD;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output register data mux.
  always_comb begin
    op_d   = x_op;
    imm_d  = x_imm;
    rd_d   = x_rd;
    word_d = instr;
    case (sel)
      SEL_HOLD: begin
        op_d   = OP_LI;
        imm_d  = hold_imm;
        rd_d   = hold_rd;
        word_d = hold_instr_q;
      end
      SEL_FUSE: begin
        op_d   = OP_LI;
        imm_d  = hold_imm + x_imm12;
        rd_d   = hold_rd;
        word_d = instr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      if (rst) hold_instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture || state_d == ST_IDLE) cnt_q <= '0;
      else if (cnt_inc && cnt_q != HOLD_LIM) cnt_q <= cnt_q + 4'd1;
      if (capture) hold_instr_q <= instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      dec_op_q    <= OP_PASS;
      imm_q       <= '0;
      rd_q        <= '0;
      instr_q     <= '0;
    end else if (flush) begin
      dec_valid_q <= 1'b0;
    end else if (load_out) begin
      dec_valid_q <= 1'b1;
      dec_op_q    <= op_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      instr_q     <= word_d;
    end else if (dec_ready) begin
      dec_valid_q <= 1'b0;
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_op     = dec_op_q;
  assign control_li = (dec_op_q == OP_LI);
  assign immediate  = imm_q;
  assign rd         = rd_q;
  assign dec_instr  = instr_q;

endmodule

// File: tb/tb_imm_decode.sv
// Self-checking bench for imm_decode: directed scenarios plus random
// instruction streams compared against a transaction-level reference model.
module tb_imm_decode;

  localparam int unsigned HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, instr_valid, flush, dec_ready;
  logic [31:0] instr;
  logic        instr_ready, dec_valid, control_li;
  logic [1:0]  dec_op;
  logic [31:0] immediate, dec_instr;
  logic [4:0]  rd;

  imm_decode #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .flush       (flush),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .control_li  (control_li),
    .dec_op      (dec_op),
    .immediate   (immediate),
    .rd          (rd),
    .dec_instr   (dec_instr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] word;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  bit   mon_en  = 1'b0;
  bit   rdy_stop = 1'b0;

  always @(negedge clk)
    if (mon_en && dec_valid && dec_ready) obs_q.push_back({dec_op, immediate, rd, dec_instr});

  // ---------------- reference model ----------------
  bit              pend;
  logic [31:0]     pend_w;
  int unsigned     idle_run;

  function automatic logic [31:0] enc_lui(input logic [4:0] r, input logic [19:0] u);
    return {u, r, 7'h37};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] r, input logic [4:0] s, input logic [11:0] i);
    return {i, s, 3'b000, r, 7'h13};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] r, input logic [4:0] s, input logic [11:0] i);
    return {i, s, 3'b010, r, 7'h03};
  endfunction

  function automatic out_t ref_decode(input logic [31:0] w);
    out_t        o;
    int          i_imm;
    logic [11:0] s_bits;
    i_imm  = $signed(w[31:20]);
    s_bits = {w[31:25], w[11:7]};
    o.word = w;
    o.rd   = w[11:7];
    o.op   = 2'd3;
    o.imm  = i_imm;
    if (w[6:0] == 7'h37) begin
      o.op  = 2'd0;
      o.imm = 32'(w[31:12]) << 12;
    end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0 && w[19:15] == 5'd0) begin
      o.op = 2'd0;
    end else if (w[6:0] == 7'h03) begin
      o.op = 2'd1;
    end else if (w[6:0] == 7'h23) begin
      o.op  = 2'd2;
      o.imm = 32'($signed(s_bits));
      o.rd  = 5'd0;
    end
    return o;
  endfunction

  function automatic void model_instr(input logic [31:0] w);
    out_t o;
    int   lo;
    if (pend) begin
      if (w[6:0] == 7'h13 && w[14:12] == 3'd0 && w[11:7] == pend_w[11:7] && w[19:15] == pend_w[11:7]) begin
        lo     = $signed(w[31:20]);
        o.op   = 2'd0;
        o.rd   = pend_w[11:7];
        o.imm  = (32'(pend_w[31:12]) << 12) + 32'(lo);
        o.word = w;
        exp_q.push_back(o);
        pend = 1'b0;
        return;
      end
      exp_q.push_back(ref_decode(pend_w));
      pend = 1'b0;
    end
    if (w[6:0] == 7'h37 && w[11:7] != 5'd0) begin
      pend     = 1'b1;
      pend_w   = w;
      idle_run = 0;
    end else begin
      exp_q.push_back(ref_decode(w));
    end
  endfunction

  function automatic void model_idle();
    if (pend) begin
      idle_run++;
      if (idle_run == HOLD_MAX + 1) begin
        exp_q.push_back(ref_decode(pend_w));
        pend = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] x;
    logic [4:0]  r;
    int          k;
    x = $urandom();
    r = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: return {x[31:12], r, 7'h37};
      3, 4:    return {x[31:20], r, 3'b000, r, 7'h13};
      5:       return {x[31:20], 5'd0, 3'b000, x[11:7], 7'h13};
      6:       return {x[31:20], x[19:15], 3'b010, x[11:7], 7'h03};
      7:       return {x[31:25], x[24:15], 3'b010, x[11:7], 7'h23};
      8:       return {x[31:20], r, 3'b000, 5'(r + 5'd1), 7'h13};
      default: return x;
    endcase
  endfunction

  // ---------------- stimulus helpers (time phase: posedge + 1) ----------------
  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] w);
    bit ok;
    ok          = 1'b0;
    instr       = w;
    instr_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = instr_ready;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout: instr_ready stayed low for instr=%h (required accept within 40 cycles)", w);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b1;
    instr = 32'h01200293; instr_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: instr_ready=%b required 0", instr_ready);
    end
    vectors++;
    if ({dec_valid, control_li, dec_op, immediate, rd, dec_instr} !== {1'b0, 1'b0, 2'd3, 32'h0, 5'd0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b li=%b op=%0d imm=%h rd=%0d instr=%h required 0 0 3 0 0 0",
               dec_valid, control_li, dec_op, immediate, rd, dec_instr);
    end
    instr_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    vectors++;
    if (dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_accept: dec_valid=%b required 0", dec_valid);
    end
  endtask

  task automatic test_addi_li();
    drive(32'h01200293);
    vectors++;
    if ({dec_valid, control_li, dec_op, immediate, rd} !== {1'b1, 1'b1, 2'd0, 32'h12, 5'd5}) begin
      miscompares++;
      $display("FAIL addi_li: valid=%b li=%b op=%0d imm=%h rd=%0d required 1 1 0 00000012 5",
               dec_valid, control_li, dec_op, immediate, rd);
    end
    idle(2);
  endtask

  task automatic test_fuse(input logic [4:0] r, input logic [19:0] u, input logic [11:0] i,
                           input logic [31:0] exp_imm, input string nm);
    drive(enc_lui(r, u));
    vectors++;
    if (dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_lui_held: dec_valid=%b required 0", nm, dec_valid);
    end
    drive(enc_addi(r, r, i));
    vectors++;
    if ({dec_valid, control_li, immediate, rd, dec_instr} !== {1'b1, 1'b1, exp_imm, r, enc_addi(r, r, i)}) begin
      miscompares++;
      $display("FAIL %s: valid=%b li=%b imm=%h rd=%0d instr=%h required 1 1 %h %0d %h",
               nm, dec_valid, control_li, immediate, rd, dec_instr, exp_imm, r, enc_addi(r, r, i));
    end
    idle(1);
    vectors++;
    if (dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_single: dec_valid=%b required 0", nm, dec_valid);
    end
    idle(1);
  endtask

  task automatic test_lone_lui();
    drive(enc_lui(5'd8, 20'hABCDE));
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (k < 5) begin
        if (dec_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL lone_early: cycle %0d dec_valid=%b required 0", k, dec_valid);
        end
      end else if ({dec_valid, control_li, immediate, rd} !== {1'b1, 1'b1, 32'hABCDE000, 5'd8}) begin
        miscompares++;
        $display("FAIL lone_emit: valid=%b li=%b imm=%h rd=%0d required 1 1 abcde000 8",
                 dec_valid, control_li, immediate, rd);
      end
    end
    idle(2);
  endtask

  task automatic test_lui_then_load();
    drive(enc_lui(5'd9, 20'h00001));
    instr = enc_lw(5'd10, 5'd2, 12'd8);
    instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL lui_load_stall: instr_ready=%b required 0", instr_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({dec_valid, dec_op, immediate, rd, instr_ready} !== {1'b1, 2'd0, 32'h00001000, 5'd9, 1'b1}) begin
      miscompares++;
      $display("FAIL lui_load_first: valid=%b op=%0d imm=%h rd=%0d ready=%b required 1 0 00001000 9 1",
               dec_valid, dec_op, immediate, rd, instr_ready);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    vectors++;
    if ({dec_valid, dec_op, immediate, rd} !== {1'b1, 2'd1, 32'd8, 5'd10}) begin
      miscompares++;
      $display("FAIL lui_load_second: valid=%b op=%0d imm=%h rd=%0d required 1 1 00000008 10",
               dec_valid, dec_op, immediate, rd);
    end
    idle(2);
  endtask

  task automatic test_stall_flush();
    drive(enc_lw(5'd11, 5'd1, 12'd4));
    dec_ready   = 1'b0;
    instr       = enc_lui(5'd12, 20'h55555);
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({instr_ready, dec_valid, dec_op, immediate, rd} !== {1'b0, 1'b1, 2'd1, 32'd4, 5'd11}) begin
        miscompares++;
        $display("FAIL stall_stable: cycle %0d ready=%b valid=%b op=%0d imm=%h rd=%0d required 0 1 1 00000004 11",
                 k, instr_ready, dec_valid, dec_op, immediate, rd);
      end
      @(posedge clk);
      #1;
    end
    dec_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: dec_valid=%b required 0", dec_valid);
    end
    flush = 1'b1;
    instr = enc_addi(5'd12, 5'd12, 12'd5);
    #1;
    vectors++;
    if (instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: instr_ready=%b required 0", instr_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    vectors++;
    if (dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: dec_valid=%b required 0", dec_valid);
    end
    drive(enc_addi(5'd12, 5'd12, 12'd5));
    vectors++;
    if ({dec_valid, dec_op, immediate, rd} !== {1'b1, 2'd3, 32'd5, 5'd12}) begin
      miscompares++;
      $display("FAIL flush_no_fuse: valid=%b op=%0d imm=%h rd=%0d required 1 3 00000005 12",
               dec_valid, dec_op, immediate, rd);
    end
    idle(8);
    vectors++;
    if (dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lost_lui: dec_valid=%b required 0", dec_valid);
    end
  endtask

  task automatic test_random_stream(input bit rand_ready, input int n);
    logic [31:0] w;
    int          g;
    int          lim;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    pend      = 1'b0;
    idle_run  = 0;
    dec_ready = 1'b1;
    mon_en    = 1'b1;
    rdy_stop  = 1'b0;
    if (rand_ready) begin
      fork
        while (!rdy_stop) begin
          @(posedge clk);
          #1;
          if (!rdy_stop) dec_ready = ($urandom_range(0, 9) < 6);
        end
      join_none
    end
    for (int i = 0; i < n; i++) begin
      w = gen_instr();
      if (rand_ready) g = $urandom_range(0, HOLD_MAX);
      else g = ($urandom_range(0, 2) == 0) ? $urandom_range(0, HOLD_MAX + 3) : 0;
      model_instr(w);
      drive(w);
      for (int j = 0; j < g; j++) begin
        model_idle();
        idle(1);
      end
    end
    rdy_stop = 1'b1;
    idle(1);
    dec_ready = 1'b1;
    idle(2 * HOLD_MAX + 6);
    if (pend) begin
      exp_q.push_back(ref_decode(pend_w));
      pend = 1'b0;
    end
    mon_en = 1'b0;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count: %0d outputs observed, %0d required", obs_q.size(), exp_q.size());
    end
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_item %0d: op=%0d imm=%h rd=%0d instr=%h required op=%0d imm=%h rd=%0d instr=%h",
                 i, obs_q[i].op, obs_q[i].imm, obs_q[i].rd, obs_q[i].word,
                 exp_q[i].op, exp_q[i].imm, exp_q[i].rd, exp_q[i].word);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b1; instr_valid = 1'b0; instr = '0;
    test_reset();
    test_addi_li();
    test_fuse(5'd6, 20'h12345, 12'h678, 32'h12345678, "fuse");
    test_fuse(5'd7, 20'h00001, 12'hFFF, 32'h00000FFF, "fuse_wrap");
    test_lone_lui();
    test_lui_then_load();
    test_stall_flush();
    test_random_stream(1'b0, 300);
    test_random_stream(1'b1, 300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
